// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, requester ids,
// and the supported memory latency range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Values double as bit positions in the packed request vector.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// On a tie the requester that was not granted last wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  req_id_e    ptr,
  output req_id_e    winner
);

  always_comb begin
    winner = REQ_IF;
    if (reqs[REQ_D] && reqs[REQ_IF]) winner = (ptr == REQ_D) ? REQ_IF : REQ_D;
    else if (reqs[REQ_D])            winner = REQ_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with MEM_LAT read latency.
// ARB_ROUND_ROBIN_EN: alternate ties between requesters; otherwise data always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_e          win_q, win_d;
  logic             we_q, we_d;
  logic             if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic             if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic             mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic [1:0] reqs;
  req_id_e    ptr;
  req_id_e    pick;

  assign reqs = {d_req, if_req};

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_ACCESS) ptr_d = win_q;
  end

  // Reset to "fetch last" so the first tie goes to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= REQ_IF;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = REQ_IF;
`endif

  arb_pick u_pick (
    .reqs   (reqs),
    .ptr    (ptr),
    .winner (pick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    we_d        = we_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'h0;
    mem_wdata_d = 32'h0;
    unique case (state_q)
      // Memory-side outputs are loaded here so they appear during ACCESS.
      ST_IDLE: if (|reqs) begin
        state_d  = ST_ACCESS;
        win_d    = pick;
        mem_en_d = 1'b1;
        if (pick == REQ_D) begin
          d_gnt_d     = 1'b1;
          we_d        = d_we;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else begin
          if_gnt_d   = 1'b1;
          we_d       = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      ST_ACCESS: begin
        state_d = ST_WAIT;
        cnt_d   = LAT_M1;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (win_q == REQ_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? 32'h0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_q       <= REQ_IF;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      we_q        <= we_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: unit 0 runs MEM_LAT=1, unit 1 runs MEM_LAT=4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req [2], d_req [2], d_we [2];
  logic [31:0] if_addr [2], d_addr [2], d_wdata [2], mem_val [2];
  logic        if_gnt [2], if_rvalid [2], d_gnt [2], d_rvalid [2], mem_en [2], mem_we [2];
  logic [31:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [31:0] mpipe [2][4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.MEM_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory model: read data valid only in the cycle MEM_LAT after the mem_en cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++)
        for (int k = 0; k < 4; k++) mpipe[u][k] <= 32'h0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        for (int k = 3; k > 0; k--) mpipe[u][k] <= mpipe[u][k-1];
        mpipe[u][0] <= (mem_en[u] && !mem_we[u]) ? mem_val[u] : 32'h0;
      end
    end
  end
  assign mem_rdata[0] = mpipe[0][0];
  assign mem_rdata[1] = mpipe[1][3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the sampling edge (cycle N+1); leaves in the IDLE cycle after RESP.
  task automatic serve(input int u, input bit isd, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input bit raise_other);
    int          lat = (u == 0) ? 1 : 4;
    logic [31:0] exp_rd = we ? 32'h0 : rd;
    checks++;
    if ({if_gnt[u], d_gnt[u], mem_en[u], mem_we[u], mem_addr[u], mem_wdata[u]} !==
        {~isd, isd, 1'b1, we, addr, wd}) begin
      errors++;
      $display("FAIL access u%0d: got gnt_if=%b gnt_d=%b en=%b we=%b addr=%h wdata=%h, want %b %b 1 %b %h %h",
               u, if_gnt[u], d_gnt[u], mem_en[u], mem_we[u], mem_addr[u], mem_wdata[u],
               ~isd, isd, we, addr, wd);
    end
    if (isd) d_req[u] = 1'b0; else if_req[u] = 1'b0;
    for (int k = 0; k < lat; k++) begin
      tick();
      if (raise_other && k == 0) begin
        if (isd) if_req[u] = 1'b1; else d_req[u] = 1'b1;
      end
      checks++;
      if ({if_gnt[u], d_gnt[u], mem_en[u], mem_we[u], if_rvalid[u], d_rvalid[u]} !== 6'b0) begin
        errors++;
        $display("FAIL wait u%0d cyc%0d: got gnt=%b%b en=%b we=%b rvalid=%b%b, want all 0",
                 u, k, if_gnt[u], d_gnt[u], mem_en[u], mem_we[u], if_rvalid[u], d_rvalid[u]);
      end
    end
    tick();
    checks++;
    if ({if_rvalid[u], d_rvalid[u], (isd ? d_rdata[u] : if_rdata[u])} !== {~isd, isd, exp_rd}) begin
      errors++;
      $display("FAIL resp u%0d: got rvalid_if=%b rvalid_d=%b rdata=%h, want %b %b %h",
               u, if_rvalid[u], d_rvalid[u], (isd ? d_rdata[u] : if_rdata[u]), ~isd, isd, exp_rd);
    end
    tick();
    checks++;
    if ({if_rvalid[u], d_rvalid[u], if_gnt[u], d_gnt[u], (isd ? d_rdata[u] : if_rdata[u])} !==
        {4'b0, exp_rd}) begin
      errors++;
      $display("FAIL after_resp u%0d: got rvalid=%b%b gnt=%b%b rdata=%h, want 0000 %h",
               u, if_rvalid[u], d_rvalid[u], if_gnt[u], d_gnt[u],
               (isd ? d_rdata[u] : if_rdata[u]), exp_rd);
    end
  endtask

  task automatic test_reset();
    if_req[0] = 1'b1;
    d_req[1]  = 1'b1;
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({if_gnt[u], if_rvalid[u], d_gnt[u], d_rvalid[u], mem_en[u], mem_we[u],
           if_rdata[u], d_rdata[u], mem_addr[u], mem_wdata[u]} !== 134'h0) begin
        errors++;
        $display("FAIL reset u%0d: got gnt=%b%b rvalid=%b%b en=%b we=%b addr=%h, want all 0",
                 u, if_gnt[u], d_gnt[u], if_rvalid[u], d_rvalid[u], mem_en[u], mem_we[u], mem_addr[u]);
      end
    end
    if_req[0] = 1'b0;
    d_req[1]  = 1'b0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    if_addr[0] = 32'h0000_0040;
    mem_val[0] = 32'h8C08_0004;
    if_req[0]  = 1'b1;
    tick();
    serve(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C08_0004, 1'b0);
  endtask

  task automatic test_write();
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h0000_0100;
    d_wdata[0] = 32'hDEAD_BEEF;
    mem_val[0] = 32'h1111_2222;
    d_req[0]   = 1'b1;
    tick();
    serve(0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    d_we[0] = 1'b0;
    checks++;
    if ({if_rdata[0], d_rdata[0]} !== {32'h8C08_0004, 32'h0}) begin
      errors++;
      $display("FAIL rdata_hold: got if_rdata=%h d_rdata=%h, want 8c080004 00000000",
               if_rdata[0], d_rdata[0]);
    end
  endtask

  // Winner of each tie re-requests immediately, so every transaction starts from a tie.
  task automatic test_tie();
    bit exp_d;
    d_we[1]    = 1'b0;
    d_wdata[1] = 32'h0;
    d_addr[1]  = 32'h0000_0080;
    if_addr[1] = 32'h0000_0044;
    d_req[1]   = 1'b1;
    if_req[1]  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      mem_val[1] = 32'hA000_0000 + 32'(t);
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      serve(1, exp_d, 1'b0, exp_d ? 32'h0000_0080 : 32'h0000_0044, 32'h0,
            32'hA000_0000 + 32'(t), 1'b0);
      if (exp_d) d_req[1] = 1'b1; else if_req[1] = 1'b1;
    end
    d_req[1]  = 1'b0;
    if_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_latency_holdoff();
    d_addr[1]  = 32'h0000_0104;
    if_addr[1] = 32'h0000_0200;
    mem_val[1] = 32'h1234_5678;
    d_req[1]   = 1'b1;
    tick();
    serve(1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1'b1);
    mem_val[1] = 32'h0BAD_F00D;
    tick();
    serve(1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_reset_mid();
    d_addr[1]  = 32'h0000_0108;
    mem_val[1] = 32'h55AA_55AA;
    d_req[1]   = 1'b1;
    tick();
    d_req[1] = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt[1], if_rvalid[1], d_gnt[1], d_rvalid[1], mem_en[1], if_rdata[1], d_rdata[1],
         mem_addr[1]} !== 101'h0) begin
      errors++;
      $display("FAIL reset_async: got rvalid=%b%b en=%b if_rdata=%h d_rdata=%h addr=%h, want all 0",
               if_rvalid[1], d_rvalid[1], mem_en[1], if_rdata[1], d_rdata[1], mem_addr[1]);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1], mem_en[1]} !== 5'b0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: got gnt=%b%b rvalid=%b%b en=%b, want 0",
                 k, if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1], mem_en[1]);
      end
    end
    if_addr[1] = 32'h0000_0300;
    mem_val[1] = 32'hCAFE_F00D;
    if_req[1]  = 1'b1;
    tick();
    serve(1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      if_req[u]  = 1'b0;
      d_req[u]   = 1'b0;
      d_we[u]    = 1'b0;
      if_addr[u] = 32'h0;
      d_addr[u]  = 32'h0;
      d_wdata[u] = 32'h0;
      mem_val[u] = 32'h0;
    end
    test_reset();
    test_fetch();
    test_write();
    test_tie();
    test_latency_holdoff();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
